uart_cmd_ctrl: RTL

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/uart_tx_seq.sv | 88 ++++++++
 rtl/uart_cmd_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared opcode values and FSM state encoding for the UART command controller.
package uart_ctrl_pkg;

  localparam logic [7:0] OPC_WRITE   = 8'hAA;
  localparam logic [7:0] OPC_READ    = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_WR_ADDR    = 4'd1;
  localparam logic [3:0] S_WR_DATA    = 4'd2;
  localparam logic [3:0] S_RD_ADDR    = 4'd3;
  localparam logic [3:0] S_RD_WAIT    = 4'd4;
  localparam logic [3:0] S_OP_A       = 4'd5;
  localparam logic [3:0] S_OP_B       = 4'd6;
  localparam logic [3:0] S_ALU_FUN    = 4'd7;
  localparam logic [3:0] S_ALU_WAIT   = 4'd8;
  localparam logic [3:0] S_TX_LOAD    = 4'd9;
  localparam logic [3:0] S_TX_WAIT_HI = 4'd10;
  localparam logic [3:0] S_TX_WAIT_LO = 4'd11;

endpackage

// File: rtl/uart_tx_seq.sv
// Sends a 1- or 2-byte burst (LSB first) to the UART transmitter, one Tx_valid pulse per byte.
// Each byte waits for Busy low, then for Busy to rise and fall again; done_o pulses after the last byte.
module uart_tx_seq
  import uart_ctrl_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               two_bytes_i,
  input  logic [2*width-1:0] data_i,
  input  logic               busy_i,
  output logic [width-1:0]   tx_data_o,
  output logic               tx_valid_o,
  output logic               done_o
);

  logic [3:0]       state_q, state_d;
  logic             idx_q, idx_d;
  logic             two_q, two_d;
  logic [width-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    two_d      = two_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = 1'b0;
          two_d   = two_bytes_i;
          state_d = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (!busy_i) begin
          tx_data_d  = idx_q ? data_i[2*width-1:width] : data_i[width-1:0];
          tx_valid_d = 1'b1;
          state_d    = S_TX_WAIT_HI;
        end
      end
      S_TX_WAIT_HI: begin
        if (busy_i) state_d = S_TX_WAIT_LO;
      end
      S_TX_WAIT_LO: begin
        if (!busy_i) begin
          if (two_q && !idx_q) begin
            idx_d   = 1'b1;
            state_d = S_TX_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= 1'b0;
      two_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      two_q      <= two_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign done_o     = done_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART command frames into register-file writes/reads and ALU operations, returning results over TX.
// Strobes fire the cycle after the completing frame; frames arriving while waiting on RF, ALU or TX are dropped.
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int width  = 8,
  parameter int ADDR_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [width-1:0]   Rx_out,
  input  logic               Rx_valid,
  input  logic               Parity_error,
  input  logic               stop_error,
  output logic [width-1:0]   TX_Data,
  output logic               Tx_valid,
  input  logic               Busy,
  output logic [ADDR_W-1:0]  RF_Addr,
  output logic               RF_WrEn,
  output logic               RF_RdEn,
  output logic [width-1:0]   RF_WrData,
  input  logic [width-1:0]   RF_RdData,
  input  logic               RF_RdData_valid,
  output logic               ALU_EN,
  output logic [3:0]         ALU_FUN,
  input  logic [2*width-1:0] ALU_OUT,
  input  logic               ALU_OUT_valid
);

  logic [3:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [width-1:0]   wrdata_q, wrdata_d;
  logic               wren_q, wren_d, rden_q, rden_d;
  logic               alu_en_q, alu_en_d;
  logic [3:0]         alu_fun_q, alu_fun_d;
  logic [2*width-1:0] result_q, result_d;
  logic               two_q, two_d, start_q, start_d;
  logic               tx_done;
  logic               frame_ok, frame_bad;

  assign frame_ok  = Rx_valid && !Parity_error && !stop_error;
  assign frame_bad = Rx_valid && (Parity_error || stop_error);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    alu_en_d  = alu_en_q;
    alu_fun_d = alu_fun_q;
    result_d  = result_q;
    two_d     = two_q;
    start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_ok) begin
          if (Rx_out == width'(OPC_WRITE))        state_d = S_WR_ADDR;
          else if (Rx_out == width'(OPC_READ))    state_d = S_RD_ADDR;
          else if (Rx_out == width'(OPC_ALU_OP))  state_d = S_OP_A;
          else if (Rx_out == width'(OPC_ALU_NOP)) state_d = S_ALU_FUN;
        end
      end
      S_WR_ADDR: begin
        if (frame_ok) begin
          addr_d  = Rx_out[ADDR_W-1:0];
          state_d = S_WR_DATA;
        end else if (frame_bad) state_d = S_IDLE;
      end
      S_WR_DATA: begin
        if (frame_ok) begin
          wrdata_d = Rx_out;
          wren_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (frame_bad) state_d = S_IDLE;
      end
      S_RD_ADDR: begin
        if (frame_ok) begin
          addr_d  = Rx_out[ADDR_W-1:0];
          rden_d  = 1'b1;
          state_d = S_RD_WAIT;
        end else if (frame_bad) state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        if (RF_RdData_valid) begin
          result_d = {{width{1'b0}}, RF_RdData};
          two_d    = 1'b0;
          start_d  = 1'b1;
          state_d  = S_TX_LOAD;
        end
      end
      // Operands land at fixed addresses 0 and 1 where the ALU picks them up.
      S_OP_A, S_OP_B: begin
        if (frame_ok) begin
          addr_d   = (state_q == S_OP_A) ? '0 : ADDR_W'(1);
          wrdata_d = Rx_out;
          wren_d   = 1'b1;
          state_d  = (state_q == S_OP_A) ? S_OP_B : S_ALU_FUN;
        end else if (frame_bad) state_d = S_IDLE;
      end
      S_ALU_FUN: begin
        if (frame_ok) begin
          alu_fun_d = Rx_out[3:0];
          alu_en_d  = 1'b1;
          state_d   = S_ALU_WAIT;
        end else if (frame_bad) state_d = S_IDLE;
      end
      S_ALU_WAIT: begin
        if (ALU_OUT_valid) begin
          alu_en_d = 1'b0;
          result_d = ALU_OUT;
          two_d    = 1'b1;
          start_d  = 1'b1;
          state_d  = S_TX_LOAD;
        end
      end
      // The load/wait-high/wait-low sub-steps live in uart_tx_seq; here we just wait for its done.
      S_TX_LOAD: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      result_q  <= '0;
      two_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      result_q  <= result_d;
      two_q     <= two_d;
      start_q   <= start_d;
    end
  end

  uart_tx_seq #(.width(width)) u_tx_seq (
    .clk_i       (CLK),
    .rst_ni      (Reset),
    .start_i     (start_q),
    .two_bytes_i (two_q),
    .data_i      (result_q),
    .busy_i      (Busy),
    .tx_data_o   (TX_Data),
    .tx_valid_o  (Tx_valid),
    .done_o      (tx_done)
  );

  assign RF_Addr   = addr_q;
  assign RF_WrEn   = wren_q;
  assign RF_RdEn   = rden_q;
  assign RF_WrData = wrdata_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;

endmodule
